// File: rtl/ahb_bm_pkg.sv
// ahb_bm_pkg: shared AHB bus-matrix encodings and the captured address-phase record.
package ahb_bm_pkg;
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;
  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] auser;
    htrans_e     trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } ahb_ctrl_t;
endpackage

// File: rtl/ahb_is_hold_reg.sv
// ahb_is_hold_reg: address/control holding register with load enable; resets to an IDLE transfer.
module ahb_is_hold_reg
  import ahb_bm_pkg::*;
(
  input  logic      HCLK,
  input  logic      HRESETn,
  input  logic      load,
  input  ahb_ctrl_t d,
  output ahb_ctrl_t q
);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/ahb_input_stage.sv
// ahb_input_stage: master-side bus-matrix stage; holds unaccepted address phases and stretches HREADYOUTS.
// Define AHB_INPUT_STAGE_ERR_CANCEL_EN to drop a pending transfer when the master goes IDLE in the first ERROR cycle.
module ahb_input_stage
  import ahb_bm_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [31:0] HAUSERS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  input  logic        active_ip,
  input  logic        ready_ip,
  input  logic        readyout_ip,
  input  logic        resp_ip,
  output logic        sel_ip,
  output logic [31:0] addr_ip,
  output logic [31:0] auser_ip,
  output logic [1:0]  trans_ip,
  output logic        write_ip,
  output logic [2:0]  size_ip,
  output logic [2:0]  burst_ip,
  output logic [3:0]  prot_ip,
  output logic [3:0]  master_ip,
  output logic        mastlock_ip,
  output logic        held_tran_ip,
  output logic        HREADYOUTS,
  output logic        HRESPS
);
  ahb_ctrl_t live, hold_q, fwd;
  logic pend_tran, data_phase, new_tran, accept, cancel;
  assign live = '{addr: HADDRS, auser: HAUSERS, trans: htrans_e'(HTRANSS), write: HWRITES,
                  size: HSIZES, burst: HBURSTS, prot: HPROTS, master: HMASTERS, mastlock: HMASTLOCKS};
  ahb_is_hold_reg u_hold (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (HREADYS),
    .d       (live),
    .q       (hold_q)
  );
  assign new_tran     = HSELS & HTRANSS[1] & HREADYS;
  assign held_tran_ip = pend_tran | (HSELS & HTRANSS[1]);
  assign accept       = held_tran_ip & active_ip & ready_ip;
`ifdef AHB_INPUT_STAGE_ERR_CANCEL_EN
  assign cancel = data_phase & resp_ip & ~readyout_ip & (htrans_e'(HTRANSS) == TRANS_IDLE);
`else
  assign cancel = 1'b0;
`endif
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pend_tran  <= 1'b0;
      data_phase <= 1'b0;
    end else begin
      pend_tran  <= (accept | cancel) ? 1'b0 : new_tran ? 1'b1 : pend_tran;
      data_phase <= accept ? 1'b1 : (data_phase & readyout_ip) ? 1'b0 : data_phase;
    end
  assign fwd         = pend_tran ? hold_q : live;
  assign sel_ip      = pend_tran | HSELS;
  assign addr_ip     = fwd.addr;
  assign auser_ip    = fwd.auser;
  assign trans_ip    = fwd.trans;
  assign write_ip    = fwd.write;
  assign size_ip     = fwd.size;
  assign burst_ip    = fwd.burst;
  assign prot_ip     = fwd.prot;
  assign master_ip   = fwd.master;
  assign mastlock_ip = fwd.mastlock;
  assign HREADYOUTS  = pend_tran ? 1'b0 : data_phase ? readyout_ip : 1'b1;
  assign HRESPS      = data_phase ? resp_ip : RESP_OKAY;
endmodule

// File: tb/tb_ahb_input_stage.sv
// tb_ahb_input_stage: table-driven directed bench for ahb_input_stage, plus reset and ERROR-cancel sequences.
module tb_ahb_input_stage;
`ifdef AHB_INPUT_STAGE_ERR_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic HSELS, HWRITES, HMASTLOCKS, HREADYS, active_ip, ready_ip, readyout_ip, resp_ip;
  logic [31:0] HADDRS, HAUSERS;
  logic [1:0] HTRANSS;
  logic [2:0] HSIZES, HBURSTS;
  logic [3:0] HPROTS, HMASTERS;
  logic sel_ip, write_ip, mastlock_ip, held_tran_ip, HREADYOUTS, HRESPS;
  logic [31:0] addr_ip, auser_ip;
  logic [1:0] trans_ip;
  logic [2:0] size_ip, burst_ip;
  logic [3:0] prot_ip, master_ip;
  int checks = 0, failures = 0;
  always #5 HCLK = ~HCLK;
  ahb_input_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HAUSERS(HAUSERS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .active_ip(active_ip),
    .ready_ip(ready_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip), .sel_ip(sel_ip),
    .addr_ip(addr_ip), .auser_ip(auser_ip), .trans_ip(trans_ip), .write_ip(write_ip),
    .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip), .master_ip(master_ip),
    .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );
  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        hready, active, ready, readyout, resp;
    logic        e_hro, e_hresp, e_held, e_sel;
    logic [31:0] e_addr;
    logic [1:0]  e_trans;
  } vec_t;
  function automatic vec_t mk(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                              input logic hready, input logic active, input logic ready,
                              input logic readyout, input logic resp, input logic e_hro,
                              input logic e_hresp, input logic e_held, input logic e_sel,
                              input logic [31:0] e_addr, input logic [1:0] e_trans);
    vec_t v;
    v.sel = sel; v.addr = addr; v.trans = trans; v.hready = hready; v.active = active;
    v.ready = ready; v.readyout = readyout; v.resp = resp; v.e_hro = e_hro; v.e_hresp = e_hresp;
    v.e_held = e_held; v.e_sel = e_sel; v.e_addr = e_addr; v.e_trans = e_trans;
    return v;
  endfunction
  task automatic drive(input vec_t v);
    HSELS = v.sel; HADDRS = v.addr; HAUSERS = ~v.addr; HTRANSS = v.trans; HREADYS = v.hready;
    active_ip = v.active; ready_ip = v.ready; readyout_ip = v.readyout; resp_ip = v.resp;
    HWRITES = 1'b1; HSIZES = 3'b010; HBURSTS = 3'b011; HPROTS = 4'b0011; HMASTERS = 4'h5;
    HMASTLOCKS = 1'b0;
  endtask
  task automatic check(input string name, input logic [37:0] exp);
    logic [37:0] act;
    act = {HREADYOUTS, HRESPS, held_tran_ip, sel_ip, trans_ip, addr_ip};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual{hro,hresp,held,sel,trans,addr}=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [37:0] expv(input vec_t v);
    return {v.e_hro, v.e_hresp, v.e_held, v.e_sel, v.e_trans, v.e_addr};
  endfunction
  vec_t mv[22];
  vec_t cv[6];
  vec_t idle_v, b_v;
  initial begin
    // sel addr trans hready active ready readyout resp | hro hresp held sel addr trans
    mv[0]  = mk(0, 32'h0,         2'b00, 1, 0, 1, 1, 0,  1, 0, 0, 0, 32'h0,         2'b00);
    mv[1]  = mk(1, 32'h2000_0000, 2'b10, 1, 1, 1, 1, 0,  1, 0, 1, 1, 32'h2000_0000, 2'b10);
    mv[2]  = mk(1, 32'h0,         2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 1, 32'h0,         2'b00);
    mv[3]  = mk(1, 32'h0,         2'b00, 0, 0, 1, 0, 0,  0, 0, 0, 1, 32'h0,         2'b00);
    mv[4]  = mk(1, 32'h0,         2'b00, 1, 0, 1, 1, 0,  1, 0, 0, 1, 32'h0,         2'b00);
    mv[5]  = mk(1, 32'h4000_0010, 2'b10, 1, 0, 1, 1, 0,  1, 0, 1, 1, 32'h4000_0010, 2'b10);
    mv[6]  = mk(1, 32'h5555_0000, 2'b10, 0, 0, 1, 1, 0,  0, 0, 1, 1, 32'h4000_0010, 2'b10);
    mv[7]  = mk(1, 32'h5555_0000, 2'b10, 0, 0, 1, 1, 0,  0, 0, 1, 1, 32'h4000_0010, 2'b10);
    mv[8]  = mk(1, 32'h5555_0000, 2'b10, 0, 0, 1, 1, 0,  0, 0, 1, 1, 32'h4000_0010, 2'b10);
    mv[9]  = mk(1, 32'h5555_0000, 2'b10, 0, 1, 1, 1, 0,  0, 0, 1, 1, 32'h4000_0010, 2'b10);
    mv[10] = mk(1, 32'h0,         2'b00, 1, 0, 1, 1, 0,  1, 0, 0, 1, 32'h0,         2'b00);
    mv[11] = mk(1, 32'h6000_0000, 2'b10, 1, 1, 1, 1, 0,  1, 0, 1, 1, 32'h6000_0000, 2'b10);
    mv[12] = mk(1, 32'h0,         2'b00, 0, 0, 1, 0, 1,  0, 1, 0, 1, 32'h0,         2'b00);
    mv[13] = mk(1, 32'h0,         2'b00, 1, 0, 1, 1, 1,  1, 1, 0, 1, 32'h0,         2'b00);
    mv[14] = mk(1, 32'h0,         2'b00, 1, 0, 1, 1, 0,  1, 0, 0, 1, 32'h0,         2'b00);
    mv[15] = mk(1, 32'h0000_0100, 2'b10, 1, 1, 1, 1, 0,  1, 0, 1, 1, 32'h0000_0100, 2'b10);
    mv[16] = mk(1, 32'h0000_0104, 2'b11, 1, 1, 1, 1, 0,  1, 0, 1, 1, 32'h0000_0104, 2'b11);
    mv[17] = mk(1, 32'h0000_0108, 2'b11, 1, 1, 1, 1, 0,  1, 0, 1, 1, 32'h0000_0108, 2'b11);
    mv[18] = mk(1, 32'h0000_010C, 2'b11, 1, 1, 1, 1, 0,  1, 0, 1, 1, 32'h0000_010C, 2'b11);
    mv[19] = mk(1, 32'h0,         2'b00, 1, 0, 1, 1, 0,  1, 0, 0, 1, 32'h0,         2'b00);
    mv[20] = mk(0, 32'h0000_0900, 2'b10, 1, 1, 1, 1, 0,  1, 0, 0, 0, 32'h0000_0900, 2'b10);
    mv[21] = mk(1, 32'h0000_0A00, 2'b01, 1, 1, 1, 1, 0,  1, 0, 0, 1, 32'h0000_0A00, 2'b01);
    // ERROR while a transfer is pending; the master goes IDLE in the first ERROR cycle
    cv[0] = mk(1, 32'h7000_0000, 2'b10, 1, 1, 1, 1, 0,  1, 0, 1, 1, 32'h7000_0000, 2'b10);
    cv[1] = mk(1, 32'h8000_0000, 2'b10, 1, 0, 1, 0, 0,  0, 0, 1, 1, 32'h8000_0000, 2'b10);
    cv[2] = mk(1, 32'h0,         2'b00, 0, 0, 1, 0, 1,  0, 1, 1, 1, 32'h8000_0000, 2'b10);
    cv[3] = CANCEL ? mk(1, 32'h0, 2'b00, 1, 0, 1, 1, 1,  1, 1, 0, 1, 32'h0,         2'b00)
                   : mk(1, 32'h0, 2'b00, 0, 0, 1, 1, 1,  0, 1, 1, 1, 32'h8000_0000, 2'b10);
    cv[4] = CANCEL ? mk(1, 32'h0, 2'b00, 1, 1, 1, 1, 0,  1, 0, 0, 1, 32'h0,         2'b00)
                   : mk(1, 32'h0, 2'b00, 0, 1, 1, 1, 0,  0, 0, 1, 1, 32'h8000_0000, 2'b10);
    cv[5] = mk(1, 32'h0,         2'b00, 1, 0, 1, 1, 0,  1, 0, 0, 1, 32'h0,         2'b00);
    idle_v = mk(0, 32'h0,        2'b00, 0, 0, 1, 1, 0,  1, 0, 0, 0, 32'h0,         2'b00);
    b_v    = mk(1, 32'h0000_B000, 2'b10, 1, 0, 1, 1, 0, 1, 0, 1, 1, 32'h0000_B000, 2'b10);
    drive(idle_v);
    @(negedge HCLK);
    check("reset", expv(idle_v));
    HRESETn = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(posedge HCLK); #1 drive(mv[i]);
      @(negedge HCLK);
      check($sformatf("main[%0d]", i), expv(mv[i]));
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge HCLK); #1 drive(cv[i]);
      @(negedge HCLK);
      check($sformatf("errcancel[%0d]", i), expv(cv[i]));
    end
    @(posedge HCLK); #1 drive(b_v);
    @(negedge HCLK);
    check("rst_setup", expv(b_v));
    @(posedge HCLK); #1 drive(idle_v);
    #1 check("rst_pending", {1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 32'h0000_B000});
    HRESETn = 1'b0;
    #1 check("rst_async", expv(idle_v));
    @(negedge HCLK) HRESETn = 1'b1;
    @(posedge HCLK); #1 drive(idle_v);
    @(negedge HCLK);
    check("rst_after", expv(idle_v));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
